alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: signed 8x8 -> 16-bit multiply by sequencing a shared,
// external combinational ALU through shift-left / add / subtract steps.
// Unsigned magnitudes are multiplied by shift-and-add, then the sign is applied
// in a final FIX step (0 - product when the operand signs differ).
// Optional build macro: MUL_EARLY_EXIT_EN -- stop iterating once the remaining
// multiplier bits are all zero (result unchanged, latency shorter).
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW   = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [OPW-1:0]   mcand,
  input  logic [OPW-1:0]   mplier,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int IW = $clog2(OPW);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ADD,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_abs_q, mcand_abs_d;
  logic [OPW-1:0]   mplier_abs_q, mplier_abs_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] shifted_q, shifted_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [IW-1:0]    i_q, i_d;

  // Magnitudes of the incoming operands; -128 maps to 128 as an unsigned value.
  logic [OPW-1:0] mcand_mag;
  logic [OPW-1:0] mplier_mag;
  logic           last_iter;

  assign mcand_mag  = mcand[OPW-1]  ? (~mcand  + {{(OPW-1){1'b0}}, 1'b1}) : mcand;
  assign mplier_mag = mplier[OPW-1] ? (~mplier + {{(OPW-1){1'b0}}, 1'b1}) : mplier;
  assign last_iter  = (i_q == IW'(OPW - 1));

  // State and datapath registers, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mcand_abs_q  <= '0;
      mplier_abs_q <= '0;
      neg_q        <= 1'b0;
      shifted_q    <= '0;
      product_q    <= '0;
      i_q          <= '0;
    end else begin
      state_q      <= state_d;
      mcand_abs_q  <= mcand_abs_d;
      mplier_abs_q <= mplier_abs_d;
      neg_q        <= neg_d;
      shifted_q    <= shifted_d;
      product_q    <= product_d;
      i_q          <= i_d;
    end
  end

  // Next-state and register-update logic; ALU results are captured on the step edges.
  always_comb begin
    state_d      = state_q;
    mcand_abs_d  = mcand_abs_q;
    mplier_abs_d = mplier_abs_q;
    neg_d        = neg_q;
    shifted_d    = shifted_q;
    product_d    = product_q;
    i_d          = i_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          mcand_abs_d  = {{(WIDTH-OPW){1'b0}}, mcand_mag};
          mplier_abs_d = mplier_mag;
          neg_d        = mcand[OPW-1] ^ mplier[OPW-1];
          product_d    = '0;
          i_d          = '0;
          state_d      = S_SHIFT;
`ifdef MUL_EARLY_EXIT_EN
          if (mplier_mag == '0) state_d = S_FIX;
`endif
        end
      end
      S_SHIFT: begin
        shifted_d = alu_result;
        state_d   = S_ADD;
      end
      S_ADD: begin
        product_d = alu_result;
        if (last_iter) begin
          state_d = S_FIX;
        end else begin
          i_d     = i_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = S_SHIFT;
`ifdef MUL_EARLY_EXIT_EN
          // Double shift keeps the amount in range when i_q is the top index.
          if (((mplier_abs_q >> i_q) >> 1) == '0) state_d = S_FIX;
`endif
        end
      end
      S_FIX: begin
        product_d = alu_result;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs and ALU operand drive, decoded from the registered state.
  always_comb begin
    start_ready = (state_q == S_IDLE);
    done_valid  = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
    product     = product_q;
    alu_op      = OP_ADD;
    alu_a       = '0;
    alu_b       = '0;
    case (state_q)
      S_SHIFT: begin
        alu_op = OP_SLL;
        alu_a  = mcand_abs_q;
        alu_b  = {{(WIDTH-IW){1'b0}}, i_q};
      end
      S_ADD: begin
        alu_op = OP_ADD;
        alu_a  = product_q;
        alu_b  = mplier_abs_q[i_q] ? shifted_q : '0;
      end
      S_FIX: begin
        alu_op = neg_q ? OP_SUB : OP_ADD;
        alu_a  = product_q;
        alu_b  = '0;
      end
      default: begin
        alu_op = OP_ADD;
        alu_a  = '0;
        alu_b  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed testbench for alu_mul_sequencer with a behavioural model of the
// shared ALU. Latency expectations follow the MUL_EARLY_EXIT_EN build macro.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [7:0]  mcand = '0;
  logic [7:0]  mplier = '0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [15:0] product;
  logic        busy;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  int checks = 0;
  int errors = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  alu_mul_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .mcand      (mcand),
    .mplier     (mplier),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .product    (product),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // External ALU: add, sub (b-a), shift-left.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_b - alu_a;
      3'b101:  alu_result = alu_a << alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_start_ready"}, {15'b0, start_ready}, 16'd1);
    check({tag, "_done_valid"},  {15'b0, done_valid},  16'd0);
    check({tag, "_busy"},        {15'b0, busy},        16'd0);
    check({tag, "_alu_op"},      {13'b0, alu_op},      16'd0);
    check({tag, "_alu_a"},       alu_a,                16'd0);
    check({tag, "_alu_b"},       alu_b,                16'd0);
  endtask

  // Present operands for one edge, then scramble them to prove they were latched.
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    mcand = a;
    mplier = b;
    start_valid = 1'b1;
    check("accept_start_ready", {15'b0, start_ready}, 16'd1);
    tick();
    start_valid = 1'b0;
    mcand = 8'h55;
    mplier = 8'h55;
  endtask

  // Bounded wait for done_valid; also tracks busy/start_ready and add-operand bits.
  task automatic wait_done(output int edges, output bit hs_ok, output logic [15:0] add_b_or);
    edges = 0;
    hs_ok = 1'b1;
    add_b_or = '0;
    while (!done_valid && edges < 40) begin
      if (!busy || start_ready) hs_ok = 1'b0;
      if (alu_op == 3'b000) add_b_or = add_b_or | alu_b;
      tick();
      edges++;
    end
  endtask

  task automatic release_done(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check({tag, "_rel_done_valid"},  {15'b0, done_valid},  16'd0);
    check({tag, "_rel_start_ready"}, {15'b0, start_ready}, 16'd1);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int exp_lat, input bit do_release);
    int          edges;
    bit          hs_ok;
    logic [15:0] bor;
    accept(a, b);
    wait_done(edges, hs_ok, bor);
    check({tag, "_latency"}, 16'(edges), 16'(exp_lat));
    check({tag, "_product"}, product, exp_p);
    check({tag, "_busy_hs"}, {15'b0, hs_ok}, 16'd1);
    $display("mul %s: 0x%02h * 0x%02h -> 0x%04h after %0d edges", tag, a, b, product, edges);
    if (do_release) release_done(tag);
  endtask

  initial begin
    int          edges;
    bit          hs_ok;
    bit          bp_ok;
    logic [15:0] bor;

    // Reset for two edges, then check the idle drive.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle("reset");
    check("reset_product", product, 16'h0000);

    // Basic multiply, held in DONE for backpressure.
    run_mul("basic_3x5", 8'd3, 8'd5, 16'h000F, EE ? 7 : 17, 1'b0);
    start_valid = 1'b1;
    mcand = 8'd1;
    mplier = 8'd1;
    bp_ok = 1'b1;
    repeat (5) begin
      tick();
      if (!done_valid || product !== 16'h000F || start_ready) bp_ok = 1'b0;
    end
    check("bp_hold", {15'b0, bp_ok}, 16'd1);
    // done_ready and start_valid together: only the done handshake completes.
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    start_valid = 1'b0;
    check("bp_rel_start_ready", {15'b0, start_ready}, 16'd1);
    check("bp_rel_done_valid",  {15'b0, done_valid},  16'd0);
    check("bp_product_kept",    product,              16'h000F);
    tick();
    check("bp_no_accept_busy",  {15'b0, busy},        16'd0);
    $display("backpressure: held 5 cycles, released to idle");

    // Sign handling.
    run_mul("m7x6",      8'hF9, 8'h06, 16'hFFD6, EE ? 7  : 17, 1'b1);
    run_mul("6xm7",      8'h06, 8'hF9, 16'hFFD6, EE ? 7  : 17, 1'b1);
    run_mul("m128xm128", 8'h80, 8'h80, 16'h4000, 17,           1'b1);
    run_mul("m128x127",  8'h80, 8'h7F, 16'hC080, EE ? 15 : 17, 1'b1);

    // Reset in SHIFT(3) of 100*100.
    accept(8'd100, 8'd100);
    repeat (6) tick();
    check("mid_shift3_op", {13'b0, alu_op}, 16'h0005);
    check("mid_shift3_a",  alu_a,           16'd100);
    check("mid_shift3_b",  alu_b,           16'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("midreset");
    check("midreset_product", product, 16'h0000);
    $display("reset mid-operation: returned to idle");
    run_mul("after_rst_2x2", 8'd2, 8'd2, 16'h0004, EE ? 5 : 17, 1'b1);

    // ALU trace for 3*2.
    accept(8'd3, 8'd2);
    tick();
    tick();
    check("trace_shift1_op", {13'b0, alu_op}, 16'h0005);
    check("trace_shift1_a",  alu_a,           16'd3);
    check("trace_shift1_b",  alu_b,           16'd1);
    tick();
    check("trace_add1_op",   {13'b0, alu_op}, 16'h0000);
    check("trace_add1_a",    alu_a,           16'd0);
    check("trace_add1_b",    alu_b,           16'd6);
    wait_done(edges, hs_ok, bor);
    check("trace_latency", 16'(edges + 3), 16'(EE ? 5 : 17));
    check("trace_product", product, 16'h0006);
    $display("mul trace_3x2: product 0x%04h after %0d edges", product, edges + 3);
    release_done("trace");

    // Zero multiplier: every add operand b stays zero.
    accept(8'hFB, 8'd0);
    wait_done(edges, hs_ok, bor);
    check("zero_latency",  16'(edges), 16'(EE ? 1 : 17));
    check("zero_add_b",    bor,        16'h0000);
    check("zero_product",  product,    16'h0000);
    $display("mul zero_m5x0: product 0x%04h after %0d edges", product, edges);
    release_done("zero");

    // Early-exit vectors (fixed latency when the feature is off).
    run_mul("ee_3x1",    8'd3, 8'd1,  16'h0003, EE ? 3 : 17, 1'b1);
    run_mul("ee_9x0",    8'd9, 8'd0,  16'h0000, EE ? 1 : 17, 1'b1);
    run_mul("ee_3xm128", 8'd3, 8'h80, 16'hFE80, 17,          1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
